// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the req/ack clock-domain-crossing handshake blocks.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_RELEASE
  } hs_state_t;

  localparam int unsigned XFER_CNT_W = 16;

  // A handshake phase is in flight whenever the FSM is away from IDLE.
  function automatic logic hs_busy(input hs_state_t state);
    return state != HS_IDLE;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for signals arriving from another clock domain.
module sync_ff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // No reset: the chain must keep tracking the remote level through a local reset.
  always_ff @(posedge clk_i) begin
    stage_q[0] <= d_i;
    for (int i = 1; i < STAGES; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit side of a 4-phase req/ack handshake: captures a word, holds it on data_o while
// req_o is up, and waits for the synchronized remote ack to rise and fall.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  ready_o,
  output logic                  req_o,
  output logic [WIDTH-1:0]      data_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic                  err_timeout_o,
  output logic [XFER_CNT_W-1:0] xfer_cnt_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TmoMax  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  hs_state_t       state_q;
  logic [CntW-1:0] tmo_cnt_q;
  logic [CntW-1:0] tmo_cnt_inc;
  logic            timeout_hit;
  logic            ack_s;

  sync_ff #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  // Holding ready low while ack_s is high keeps a new word from overlapping a remote cycle
  // that is still finishing, including one left over from a local reset.
  assign ready_o = (state_q == HS_IDLE) && !ack_s;

  always_comb begin
    tmo_cnt_inc = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + CntW'(1);
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0 && hs_busy(state_q)) begin
      timeout_hit = (tmo_cnt_q == TmoLast);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= HS_IDLE;
      req_o         <= 1'b0;
      data_o        <= '0;
      done_o        <= 1'b0;
      err_timeout_o <= 1'b0;
      xfer_cnt_o    <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        HS_IDLE: begin
          tmo_cnt_q <= '0;
          if (valid_i && ready_o) begin
            data_o  <= data_i;
            req_o   <= 1'b1;
            state_q <= HS_REQ;
          end
        end
        HS_REQ: begin
          if (ack_s) begin
            req_o     <= 1'b0;
            tmo_cnt_q <= '0;
            state_q   <= HS_RELEASE;
          end else begin
            tmo_cnt_q <= tmo_cnt_inc;
          end
        end
        HS_RELEASE: begin
          if (!ack_s) begin
            done_o     <= 1'b1;
            xfer_cnt_o <= xfer_cnt_o + XFER_CNT_W'(1);
            tmo_cnt_q  <= '0;
            state_q    <= HS_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_inc;
          end
        end
        default: begin
          req_o     <= 1'b0;
          tmo_cnt_q <= '0;
          state_q   <= HS_IDLE;
        end
      endcase
      // Sticky flag only; the FSM keeps waiting for the remote side.
      if (timeout_hit) begin
        err_timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx: single transfer, latency, back-to-back, timeout, reset, bulk count.
module tb_cdc_hs_tx;

  localparam int unsigned Width = 32;
  localparam int unsigned Sync  = 2;
  localparam int unsigned Tmo   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic [Width-1:0]  din;
  logic              ready;
  logic              req;
  logic [Width-1:0]  dout;
  logic              ack;
  logic              ack_man;
  logic              ack_auto;
  logic              auto_ack;
  logic              done;
  logic              err;
  logic [15:0]       xfer;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned viol    = 0;
  int unsigned exp_xfer;

  logic [Width-1:0] words [4];

  always #5 clk = ~clk;

  assign ack = auto_ack ? ack_auto : ack_man;

  cdc_hs_tx #(
    .WIDTH          (Width),
    .SYNC_STAGES    (Sync),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .valid_i       (valid),
    .data_i        (din),
    .ready_o       (ready),
    .req_o         (req),
    .data_o        (dout),
    .ack_i         (ack),
    .done_o        (done),
    .err_timeout_o (err),
    .xfer_cnt_o    (xfer)
  );

  // Fast remote: ack follows req half a cycle later.
  initial begin
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      ack_auto = req;
    end
  end

  // data_o must not move while req_o stays high.
  initial begin
    logic             prev_req;
    logic [Width-1:0] prev_data;
    prev_req  = 1'b0;
    prev_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_req && req && dout !== prev_data) viol++;
      prev_req  = req;
      prev_data = dout;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [Width-1:0] w);
    valid = 1'b1;
    din   = w;
    tick();
    valid = 1'b0;
  endtask

  // Drive valid continuously, advancing only on edges where ready_o was high.
  task automatic stream(input int unsigned count, input int unsigned budget, output int unsigned sent);
    int unsigned cyc;
    logic        was_ready;
    sent  = 0;
    cyc   = 0;
    valid = 1'b1;
    din   = (count == 4) ? words[0] : 32'd0;
    while (sent < count && cyc < budget) begin
      was_ready = ready;
      tick();
      cyc++;
      if (was_ready) begin
        if (count == 4) check("b2b_data", dout, words[sent]);
        sent++;
        din = (count == 4 && sent < 4) ? words[sent] : sent;
      end
    end
    valid = 1'b0;
  endtask

  task automatic wait_xfer(input int unsigned target);
    int unsigned cyc;
    cyc = 0;
    while (xfer != 16'(target) && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned sent;

    words[0] = 32'h1111_AAAA;
    words[1] = 32'h2222_BBBB;
    words[2] = 32'h3333_CCCC;
    words[3] = 32'h4444_DDDD;

    rst      = 1'b1;
    valid    = 1'b0;
    din      = '0;
    ack_man  = 1'b0;
    auto_ack = 1'b0;
    exp_xfer = 0;
    repeat (4) tick();
    rst = 1'b0;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_data", dout, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_xfer", {16'd0, xfer}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);

    // Single transfer.
    send_word(32'hDEAD_BEEF);
    din = 32'h1234_5678;
    check("t1_req_up", {31'd0, req}, 32'd1);
    check("t1_data", dout, 32'hDEAD_BEEF);
    check("t1_ready_busy", {31'd0, ready}, 32'd0);
    repeat (4) tick();
    ack_man = 1'b1;
    tick();
    tick();
    check("t1_req_hold", {31'd0, req}, 32'd1);
    tick();
    check("t1_req_fall", {31'd0, req}, 32'd0);
    repeat (2) tick();
    ack_man = 1'b0;
    tick();
    tick();
    check("t1_done_early", {31'd0, done}, 32'd0);
    tick();
    exp_xfer = 1;
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_xfer", {16'd0, xfer}, exp_xfer);
    check("t1_data_held", dout, 32'hDEAD_BEEF);
    check("t1_ready_in_done", {31'd0, ready}, 32'd1);
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd0);

    // Latency with ack edges at random phase inside the cycle.
    for (int k = 0; k < 4; k++) begin
      send_word(32'hA000_0000 + k);
      repeat (2) tick();
      #($urandom_range(0, 7));
      ack_man = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (req && n < 10);
      check("lat_req_fall", n, Sync + 1);
      #($urandom_range(0, 7));
      ack_man = 1'b0;
      n = 0;
      do begin
        tick();
        n++;
      end while (!done && n < 10);
      check("lat_done", n, Sync + 1);
      check("lat_data", dout, 32'hA000_0000 + k);
    end
    exp_xfer += 4;
    check("lat_xfer", {16'd0, xfer}, exp_xfer);

    // Back-to-back with the fast remote.
    auto_ack = 1'b1;
    stream(4, 400, sent);
    check("b2b_sent", sent, 32'd4);
    exp_xfer += 4;
    wait_xfer(exp_xfer);
    check("b2b_xfer", {16'd0, xfer}, exp_xfer);
    check("b2b_stable", viol, 32'd0);
    check("b2b_no_err", {31'd0, err}, 32'd0);
    repeat (3) tick();
    auto_ack = 1'b0;

    // Timeout: remote silent for 16 cycles in REQ.
    send_word(32'h0BAD_F00D);
    repeat (Tmo - 1) tick();
    check("tmo_not_yet", {31'd0, err}, 32'd0);
    tick();
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_req_held", {31'd0, req}, 32'd1);
    ack_man = 1'b1;
    repeat (Sync + 1) tick();
    check("tmo_late_req_fall", {31'd0, req}, 32'd0);
    ack_man = 1'b0;
    repeat (Sync + 1) tick();
    exp_xfer += 1;
    check("tmo_done", {31'd0, done}, 32'd1);
    check("tmo_xfer", {16'd0, xfer}, exp_xfer);
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
    check("tmo_data", dout, 32'h0BAD_F00D);

    // Reset mid-REQ while the remote holds ack high.
    send_word(32'hCAFE_0001);
    ack_man = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_req", {31'd0, req}, 32'd0);
    check("mid_rst_data", dout, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    valid = 1'b1;
    din   = 32'h5555_5555;
    repeat (6) tick();
    check("ack_stuck_ready", {31'd0, ready}, 32'd0);
    check("ack_stuck_req", {31'd0, req}, 32'd0);
    check("ack_stuck_err", {31'd0, err}, 32'd0);
    valid   = 1'b0;
    ack_man = 1'b0;
    tick();
    check("rel_ready_early", {31'd0, ready}, 32'd0);
    tick();
    check("rel_ready", {31'd0, ready}, 32'd1);
    check("rel_xfer", {16'd0, xfer}, 32'd0);

    // Bulk transfers through the fast remote.
    auto_ack = 1'b1;
    stream(300, 4000, sent);
    check("bulk_sent", sent, 32'd300);
    wait_xfer(300);
    check("bulk_xfer", {16'd0, xfer}, 32'd300);
    check("bulk_last_data", dout, 32'd299);
    check("bulk_stable", viol, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
